// File: rtl/rr_mux_sched.sv
// rtl/rr_mux_sched.sv - round-robin scheduler feeding one shared recursive mux into a valid/ready port
// recurse_mux builds a 2**S:1 word mux as a tree of 2:1 stages, one per select bit.

module recurse_mux #(
    parameter int S = 2,
    parameter int T = 3
) (
    input  logic [S-1:0]         ctrl,
    input  logic [(2**S)*T-1:0]  in,
    output logic [T-1:0]         out
);
    localparam int HALF = (2**(S-1)) * T;

    generate
        if (S == 1) begin : g_leaf
            assign out = ctrl[0] ? in[2*T-1:T] : in[T-1:0];
        end else begin : g_node
            logic [T-1:0] lo_out;
            logic [T-1:0] hi_out;

            recurse_mux #(.S(S-1), .T(T)) u_lo (
                .ctrl (ctrl[S-2:0]),
                .in   (in[HALF-1:0]),
                .out  (lo_out)
            );

            recurse_mux #(.S(S-1), .T(T)) u_hi (
                .ctrl (ctrl[S-2:0]),
                .in   (in[2*HALF-1:HALF]),
                .out  (hi_out)
            );

            assign out = ctrl[S-1] ? hi_out : lo_out;
        end
    endgenerate
endmodule

module rr_mux_sched #(
    parameter int S = 2,
    parameter int T = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [(2**S)-1:0]    req,
    input  logic [(2**S)*T-1:0]  in,
    output logic [(2**S)-1:0]    ack,
    output logic [T-1:0]         out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [S-1:0]         sel,
    output logic                 busy
);
    localparam int N = 2**S;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [S-1:0]   ptr_q, ptr_d;
    logic [S-1:0]   sel_q, sel_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [T-1:0]   out_data_q, out_data_d;
    logic           out_valid_q, out_valid_d;

    logic [T-1:0]   mux_out;
    logic [S-1:0]   grant_idx;
    logic [S-1:0]   cand;
    logic           grant_hit;

    recurse_mux #(.S(S), .T(T)) u_mux (
        .ctrl (sel_q),
        .in   (in),
        .out  (mux_out)
    );

    // Search starts at ptr so the last-served requester ends up with lowest priority.
    always_comb begin
        grant_idx = ptr_q;
        grant_hit = 1'b0;
        cand      = ptr_q;
        for (int j = 0; j < N; j++) begin
            cand = ptr_q + S'(j);
            if (!grant_hit && req[cand]) begin
                grant_idx = cand;
                grant_hit = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        sel_d       = sel_q;
        ack_d       = '0;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (grant_hit) begin
                    sel_d   = grant_idx;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                out_data_d   = mux_out;
                out_valid_d  = 1'b1;
                ack_d[sel_q] = 1'b1;
                state_d      = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    ptr_d       = sel_q + 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ptr_q       <= '0;
            sel_q       <= '0;
            ack_q       <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            sel_q       <= sel_d;
            ack_q       <= ack_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign ack       = ack_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign sel       = sel_q;
    assign busy      = (state_q != IDLE);
endmodule

// File: tb/tb_rr_mux_sched.sv
// tb/tb_rr_mux_sched.sv - directed self-checking bench for rr_mux_sched (S=2, T=3)

module tb_rr_mux_sched;
    localparam int S = 2;
    localparam int T = 3;
    localparam int N = 4;

    logic            clk;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*T-1:0]  in;
    logic [N-1:0]    ack;
    logic [T-1:0]    out_data;
    logic            out_valid;
    logic            out_ready;
    logic [S-1:0]    sel;
    logic            busy;

    int n_cmp;
    int n_bad;

    rr_mux_sched #(.S(S), .T(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in        (in),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full word at out_ready=1: IDLE->LOAD, LOAD->HOLD, HOLD->IDLE; word i carries i+1.
    task automatic run_word(input string tag, input int idx, input logic [N-1:0] req_after);
        logic [N-1:0] exp_ack;
        exp_ack = '0;
        exp_ack[idx] = 1'b1;
        tick();
        check({tag, ".sel"},  32'(sel), 32'(idx));
        check({tag, ".busy"}, 32'(busy), 32'd1);
        check({tag, ".ack0"}, 32'(ack), 32'd0);
        check({tag, ".ov0"},  32'(out_valid), 32'd0);
        tick();
        check({tag, ".ack"},  32'(ack), 32'(exp_ack));
        check({tag, ".ov"},   32'(out_valid), 32'd1);
        check({tag, ".data"}, 32'(out_data), 32'(idx + 1));
        req = req_after;
        tick();
        check({tag, ".ackoff"}, 32'(ack), 32'd0);
        check({tag, ".ovoff"},  32'(out_valid), 32'd0);
        check({tag, ".idle"},   32'(busy), 32'd0);
    endtask

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        reset     = 1'b1;
        req       = '0;
        out_ready = 1'b0;
        in        = {3'd4, 3'd3, 3'd2, 3'd1};

        // 1: reset state
        tick();
        tick();
        check("rst.ov",   32'(out_valid), 32'd0);
        check("rst.ack",  32'(ack), 32'd0);
        check("rst.sel",  32'(sel), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.data", 32'(out_data), 32'd0);
        reset = 1'b0;

        // 2: single requester 0
        req = 4'b0001;
        out_ready = 1'b1;
        run_word("t2", 0, 4'b0000);
        tick();
        check("t2.quiet", 32'(busy), 32'd0);

        // 3: all requesting from ptr=0 -> 0,1,2,3,0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        req = 4'b1111;
        run_word("t3a", 0, 4'b1111);
        run_word("t3b", 1, 4'b1111);
        run_word("t3c", 2, 4'b1111);
        run_word("t3d", 3, 4'b1111);
        run_word("t3e", 0, 4'b0000);

        // 4: ptr=1 -> serve 2 to reach ptr=3, then 1001 gives 3 then 0, then 3 again
        req = 4'b0100;
        run_word("t4pre", 2, 4'b1001);
        run_word("t4a", 3, 4'b1001);
        run_word("t4b", 0, 4'b1001);
        run_word("t4c", 3, 4'b0110);

        // 5: ptr=0, req 0110 -> grant 1, stall 5 cycles in HOLD
        out_ready = 1'b0;
        tick();
        check("t5.sel", 32'(sel), 32'd1);
        tick();
        check("t5.ack", 32'(ack), 32'b0010);
        for (int c = 0; c < 5; c++) begin
            tick();
            check("t5.hold.data", 32'(out_data), 32'd2);
            check("t5.hold.ov",   32'(out_valid), 32'd1);
            check("t5.hold.sel",  32'(sel), 32'd1);
            check("t5.hold.ack",  32'(ack), 32'd0);
        end
        req = 4'b0100;
        out_ready = 1'b1;
        tick();
        check("t5.rel.ov", 32'(out_valid), 32'd0);
        run_word("t5next", 2, 4'b0001);

        // 6: ptr=3, capture word 0 and reset while it sits in HOLD
        out_ready = 1'b0;
        tick();
        tick();
        tick();
        check("t6.pre.ov", 32'(out_valid), 32'd1);
        check("t6.pre.sel", 32'(sel), 32'd0);
        reset = 1'b1;
        req = 4'b1100;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        check("t6.ov",   32'(out_valid), 32'd0);
        check("t6.busy", 32'(busy), 32'd0);
        check("t6.ack",  32'(ack), 32'd0);
        check("t6.sel",  32'(sel), 32'd0);
        // ptr back at 0 means 2 wins over 3
        run_word("t6serve", 2, 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
